debounce_scan_ctrl: RTL and testbench

//  Time-multiplexed debounce scheduler for N_CH slow inputs (switches, card-detect, write-protect).
//  A single compare/increment engine is shared across channels; each scan tick it visits the

---
 rtl/debounce_scan_ctrl.sv | 130 +++++++++++++
 tb/tb_debounce_scan_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_scan_ctrl.sv
// Time-multiplexed debounce: one shared compare/increment engine visits each channel once per
// scan tick, flipping a channel's stable level after DEB_TICKS consecutive differing visits.
module debounce_scan_ctrl #(
  parameter int          N_CH      = 8,
  parameter logic [15:0] TICK_DIV  = 16'd1000,
  parameter logic [7:0]  DEB_TICKS = 8'd20
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            enable,
  input  logic [N_CH-1:0] sig_in,
  output logic [N_CH-1:0] sig_out,
  output logic            chg_strb,
  output logic [4:0]      chg_ch,
  output logic            chg_lvl,
  output logic            busy,
  output logic            overrun
);

  localparam int          CW        = (DEB_TICKS <= 8'd1) ? 1 : $clog2(int'(DEB_TICKS));
  localparam int          CHW       = (N_CH <= 2) ? 1 : $clog2(N_CH);
  localparam logic [CW-1:0]  CNT_MAX   = CW'(DEB_TICKS - 8'd1);
  localparam logic [CHW-1:0] CH_LAST   = CHW'(N_CH - 1);
  localparam logic [15:0]    PRESC_MAX = TICK_DIV - 16'd1;

  typedef enum logic {IDLE, SCAN} state_t;

  logic [N_CH-1:0] sync1_q, sync_q;
  logic [N_CH-1:0] sig_out_q, sig_out_d;
  logic [CW-1:0]   cnt_q [N_CH];
  logic [CW-1:0]   cnt_d [N_CH];
  logic [15:0]     presc_q, presc_d;
  state_t          state_q, state_d;
  logic [CHW-1:0]  ch_q, ch_d;
  logic            chg_strb_q, chg_strb_d;
  logic [4:0]      chg_ch_q, chg_ch_d;
  logic            chg_lvl_q, chg_lvl_d;
  logic            busy_q, busy_d;
  logic            overrun_q, overrun_d;
  logic            tick;

  // Prescaler is parked at zero while disabled so re-enabling gives a full period before the next tick.
  always_comb begin
    presc_d = presc_q;
    tick    = 1'b0;
    if (!enable) begin
      presc_d = '0;
    end else if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      tick    = 1'b1;
    end else begin
      presc_d = presc_q + 16'd1;
    end
  end

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    overrun_d  = overrun_q;
    sig_out_d  = sig_out_q;
    cnt_d      = cnt_q;
    chg_strb_d = 1'b0;
    chg_ch_d   = chg_ch_q;
    chg_lvl_d  = chg_lvl_q;
    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = SCAN;
          ch_d    = '0;
        end
      end
      SCAN: begin
        // A tick landing inside a pass is dropped; the pass itself carries on.
        if (tick) overrun_d = 1'b1;
        if (sync_q[ch_q] == sig_out_q[ch_q]) begin
          cnt_d[ch_q] = '0;
        end else if (cnt_q[ch_q] == CNT_MAX) begin
          sig_out_d[ch_q] = sync_q[ch_q];
          cnt_d[ch_q]     = '0;
          chg_strb_d      = 1'b1;
          chg_ch_d        = 5'(ch_q);
          chg_lvl_d       = sync_q[ch_q];
        end else begin
          cnt_d[ch_q] = cnt_q[ch_q] + 1'b1;
        end
        if (ch_q == CH_LAST) state_d = IDLE;
        else                 ch_d    = ch_q + 1'b1;
      end
    endcase
    busy_d = (state_d == SCAN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= '0;
      sync_q     <= '0;
      sig_out_q  <= '0;
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
      presc_q    <= '0;
      state_q    <= IDLE;
      ch_q       <= '0;
      chg_strb_q <= 1'b0;
      chg_ch_q   <= '0;
      chg_lvl_q  <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      sync1_q    <= sig_in;
      sync_q     <= sync1_q;
      sig_out_q  <= sig_out_d;
      cnt_q      <= cnt_d;
      presc_q    <= presc_d;
      state_q    <= state_d;
      ch_q       <= ch_d;
      chg_strb_q <= chg_strb_d;
      chg_ch_q   <= chg_ch_d;
      chg_lvl_q  <= chg_lvl_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
    end
  end

  assign sig_out  = sig_out_q;
  assign chg_strb = chg_strb_q;
  assign chg_ch   = chg_ch_q;
  assign chg_lvl  = chg_lvl_q;
  assign busy     = busy_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// Directed bench for debounce_scan_ctrl: per-pass vector table on a 4-channel instance plus
// hand-written enable, reset and overrun sequences (second instance with fast ticks, DEB_TICKS=1).
module tb_debounce_scan_ctrl;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, enable;
  logic [3:0] sig_in, sig_out;
  logic       chg_strb, chg_lvl, busy, overrun;
  logic [4:0] chg_ch;

  logic       rst2_n, enable2;
  logic [3:0] sig_in2, sig_out2;
  logic       chg_strb2, chg_lvl2, busy2, overrun2;
  logic [4:0] chg_ch2;

  debounce_scan_ctrl #(.N_CH(4), .TICK_DIV(16'd8), .DEB_TICKS(8'd3)) u_dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .sig_in(sig_in), .sig_out(sig_out),
    .chg_strb(chg_strb), .chg_ch(chg_ch), .chg_lvl(chg_lvl), .busy(busy), .overrun(overrun)
  );

  debounce_scan_ctrl #(.N_CH(4), .TICK_DIV(16'd4), .DEB_TICKS(8'd1)) u_dut2 (
    .clk(clk), .reset_n(rst2_n), .enable(enable2), .sig_in(sig_in2), .sig_out(sig_out2),
    .chg_strb(chg_strb2), .chg_ch(chg_ch2), .chg_lvl(chg_lvl2), .busy(busy2), .overrun(overrun2)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] sin;
    logic [3:0] exp_out;
    logic [7:0] exp_n;
    logic [4:0] exp_first;
    logic [4:0] exp_last;
    logic       exp_lvl;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Applies one input pattern, then observes the next full scan pass.
  task automatic run_pass(input vec_t v, input string tag);
    int to, off, n, bcyc, first_off, last_off;
    logic [4:0] fch, lch;
    logic llvl;
    sig_in = v.sin;
    to = 0;
    while (busy !== 1'b1 && to < 40) begin
      @(negedge clk);
      to++;
    end
    if (busy !== 1'b1) begin
      chk({tag, "_start_timeout"}, 32'd0, 32'd1);
      return;
    end
    off = 0; n = 0; bcyc = 0; first_off = 0; last_off = 0;
    fch = '0; lch = '0; llvl = 1'b0;
    while (off < 20) begin
      if (busy) bcyc++;
      if (chg_strb) begin
        if (n == 0) begin
          fch = chg_ch;
          first_off = off;
        end
        lch = chg_ch;
        llvl = chg_lvl;
        last_off = off;
        n++;
      end
      if (!busy) break;
      @(negedge clk);
      off++;
    end
    chk({tag, "_busy_cycles"}, 32'(bcyc), 32'd4);
    chk({tag, "_strobes"}, 32'(n), 32'(v.exp_n));
    chk({tag, "_sig_out"}, 32'(sig_out), 32'(v.exp_out));
    if (v.exp_n != 0) begin
      chk({tag, "_first_ch"}, 32'(fch), 32'(v.exp_first));
      chk({tag, "_last_ch"}, 32'(lch), 32'(v.exp_last));
      chk({tag, "_lvl"}, 32'(llvl), 32'(v.exp_lvl));
      chk({tag, "_first_latency"}, 32'(first_off), 32'(v.exp_first) + 32'd1);
      chk({tag, "_strobe_gap"}, 32'(last_off - first_off), 32'(v.exp_last) - 32'(v.exp_first));
    end
    $display("pass %s: sig_in=%b sig_out=%b strobes=%0d first_ch=%0d last_ch=%0d lvl=%0b",
             tag, v.sin, sig_out, n, fch, lch, llvl);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int to, bc, rises, n;
    bit found;

    // Two channels flip together, then all four fall together, then ch0 rises.
    vecs[0]  = '{4'b0100, 4'b0000, 8'd0, 5'd0, 5'd0, 1'b0};
    vecs[1]  = '{4'b0100, 4'b0000, 8'd0, 5'd0, 5'd0, 1'b0};
    vecs[2]  = '{4'b0100, 4'b0100, 8'd1, 5'd2, 5'd2, 1'b1};
    vecs[3]  = '{4'b0100, 4'b0100, 8'd0, 5'd0, 5'd0, 1'b0};
    vecs[4]  = '{4'b0110, 4'b0100, 8'd0, 5'd0, 5'd0, 1'b0};
    vecs[5]  = '{4'b0110, 4'b0100, 8'd0, 5'd0, 5'd0, 1'b0};
    vecs[6]  = '{4'b0100, 4'b0100, 8'd0, 5'd0, 5'd0, 1'b0};
    vecs[7]  = '{4'b0110, 4'b0100, 8'd0, 5'd0, 5'd0, 1'b0};
    vecs[8]  = '{4'b0110, 4'b0100, 8'd0, 5'd0, 5'd0, 1'b0};
    vecs[9]  = '{4'b0110, 4'b0110, 8'd1, 5'd1, 5'd1, 1'b1};
    vecs[10] = '{4'b1111, 4'b0110, 8'd0, 5'd0, 5'd0, 1'b0};
    vecs[11] = '{4'b1111, 4'b0110, 8'd0, 5'd0, 5'd0, 1'b0};
    vecs[12] = '{4'b1111, 4'b1111, 8'd2, 5'd0, 5'd3, 1'b1};
    vecs[13] = '{4'b0000, 4'b1111, 8'd0, 5'd0, 5'd0, 1'b0};
    vecs[14] = '{4'b0000, 4'b1111, 8'd0, 5'd0, 5'd0, 1'b0};
    vecs[15] = '{4'b0000, 4'b0000, 8'd4, 5'd0, 5'd3, 1'b0};
    vecs[16] = '{4'b0001, 4'b0000, 8'd0, 5'd0, 5'd0, 1'b0};
    vecs[17] = '{4'b0001, 4'b0000, 8'd0, 5'd0, 5'd0, 1'b0};
    vecs[18] = '{4'b0001, 4'b0001, 8'd1, 5'd0, 5'd0, 1'b1};

    reset_n = 1'b0; enable = 1'b1; sig_in = 4'b0000;
    rst2_n = 1'b0; enable2 = 1'b1; sig_in2 = 4'b0000;
    repeat (3) @(negedge clk);
    chk("reset_sig_out", 32'(sig_out), 32'd0);
    chk("reset_chg_strb", 32'(chg_strb), 32'd0);
    chk("reset_chg_ch", 32'(chg_ch), 32'd0);
    chk("reset_chg_lvl", 32'(chg_lvl), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_overrun", 32'(overrun), 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 19; i++) run_pass(vecs[i], $sformatf("v%0d", i));
    chk("no_overrun_normal", 32'(overrun), 32'd0);

    // enable dropped inside a pass: pass finishes, then no further ticks.
    to = 0;
    while (busy !== 1'b1 && to < 40) begin @(negedge clk); to++; end
    chk("en_pass_start", 32'(busy), 32'd1);
    bc = 0;
    while (busy && bc < 20) begin
      bc++;
      if (bc == 2) enable = 1'b0;
      @(negedge clk);
    end
    chk("en_pass_completes", 32'(bc), 32'd4);
    rises = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy) rises++;
    end
    chk("en_no_ticks", 32'(rises), 32'd0);
    chk("en_sig_out_held", 32'(sig_out), 32'b0001);
    enable = 1'b1;
    n = 0;
    while (!busy && n < 30) begin @(negedge clk); n++; end
    chk("en_restart_latency", 32'(n), 32'd8);
    $display("enable sequence: pass_cycles=%0d idle_rises=%0d restart_latency=%0d", bc, rises, n);
    to = 0;
    while (busy && to < 20) begin @(negedge clk); to++; end

    // Reset lands while ch1 is one visit away from flipping.
    run_pass('{4'b0011, 4'b0001, 8'd0, 5'd0, 5'd0, 1'b0}, "r0");
    run_pass('{4'b0011, 4'b0001, 8'd0, 5'd0, 5'd0, 1'b0}, "r1");
    to = 0;
    while (busy !== 1'b1 && to < 40) begin @(negedge clk); to++; end
    chk("rst_pass_start", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_async_sig_out", 32'(sig_out), 32'd0);
    chk("rst_async_busy", 32'(busy), 32'd0);
    chk("rst_async_strb", 32'(chg_strb), 32'd0);
    chk("rst_async_chg_lvl", 32'(chg_lvl), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    n = 0;
    repeat (7) begin
      @(negedge clk);
      if (chg_strb) n++;
    end
    chk("rst_no_strobe_after_release", 32'(n), 32'd0);
    $display("reset sequence: strobes_after_release=%0d sig_out=%b", n, sig_out);
    run_pass('{4'b0011, 4'b0000, 8'd0, 5'd0, 5'd0, 1'b0}, "r2");
    run_pass('{4'b0011, 4'b0000, 8'd0, 5'd0, 5'd0, 1'b0}, "r3");
    run_pass('{4'b0011, 4'b0011, 8'd2, 5'd0, 5'd1, 1'b1}, "r4");

    // Fast-tick instance: overrun on the first pass, DEB_TICKS=1 flips on first differing visit.
    rst2_n = 1'b1;
    to = 0;
    while (busy2 !== 1'b1 && to < 40) begin @(negedge clk); to++; end
    chk("ovr_pass_start", 32'(busy2), 32'd1);
    chk("ovr_clear_before", 32'(overrun2), 32'd0);
    bc = 0;
    while (busy2 && bc < 20) begin bc++; @(negedge clk); end
    chk("ovr_pass_undisturbed", 32'(bc), 32'd4);
    chk("ovr_set_after_pass", 32'(overrun2), 32'd1);
    sig_in2 = 4'b0010;
    found = 1'b0;
    n = 0;
    while (!found && n < 14) begin
      @(negedge clk);
      n++;
      if (chg_strb2) found = 1'b1;
    end
    chk("deb1_strobe_seen", 32'(found), 32'd1);
    chk("deb1_chg_ch", 32'(chg_ch2), 32'd1);
    chk("deb1_chg_lvl", 32'(chg_lvl2), 32'd1);
    chk("deb1_sig_out", 32'(sig_out2), 32'b0010);
    $display("fast instance: strobe_after=%0d chg_ch=%0d sig_out=%b overrun=%0b",
             n, chg_ch2, sig_out2, overrun2);
    repeat (40) @(negedge clk);
    chk("ovr_sticky", 32'(overrun2), 32'd1);
    rst2_n = 1'b0;
    #1;
    chk("ovr_cleared_by_reset", 32'(overrun2), 32'd0);
    chk("deb1_sig_out_reset", 32'(sig_out2), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
